// File: rtl/usb_bus_arb.sv
// Round-robin two-master arbiter for the usb CSR/EP-status bus, with per-master lock and transfer watchdog.
// Latency: grant one cycle after request, forced idle gap after every ack; masters hold cyc until ack (abort by dropping cyc).
module usb_bus_arb #(
   parameter int TIMEOUT_W = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] m0_addr,
   input  logic [15:0] m0_din,
   output logic [15:0] m0_dout,
   input  logic        m0_cyc,
   input  logic        m0_we,
   input  logic        m0_lock,
   output logic        m0_ack,
   output logic        m0_err,
   input  logic [11:0] m1_addr,
   input  logic [15:0] m1_din,
   output logic [15:0] m1_dout,
   input  logic        m1_cyc,
   input  logic        m1_we,
   input  logic        m1_lock,
   output logic        m1_ack,
   output logic        m1_err,
   output logic [11:0] s_addr,
   output logic [15:0] s_din,
   input  logic [15:0] s_dout,
   output logic        s_cyc,
   output logic        s_we,
   input  logic        s_ack,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

   state_t               state_q, state_d;
   logic                 last_gnt_q, last_gnt_d;
   logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic                 gnt0, gnt1, tmo, last_lock;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         last_gnt_q <= 1'b1;
         tmo_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
         tmo_cnt_q  <= tmo_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      last_gnt_d = last_gnt_q;
      tmo_cnt_d  = tmo_cnt_q;
      gnt0       = (state_q == GNT0);
      gnt1       = (state_q == GNT1);
      tmo        = (gnt0 | gnt1) & (&tmo_cnt_q) & ~s_ack;
      last_lock  = last_gnt_q ? m1_lock : m0_lock;

      case (state_q)
         IDLE: begin
            // Counter is held at zero here so every grant starts a fresh watchdog window.
            tmo_cnt_d = '0;
            if (m0_cyc & m1_cyc) begin
               last_gnt_d = last_lock ? last_gnt_q : ~last_gnt_q;
               state_d    = last_gnt_d ? GNT1 : GNT0;
            end else if (m0_cyc) begin
               last_gnt_d = 1'b0;
               state_d    = GNT0;
            end else if (m1_cyc) begin
               last_gnt_d = 1'b1;
               state_d    = GNT1;
            end
         end
         GNT0: begin
            tmo_cnt_d = tmo_cnt_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
            if (s_ack | tmo | ~m0_cyc) state_d = IDLE;
         end
         GNT1: begin
            tmo_cnt_d = tmo_cnt_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
            if (s_ack | tmo | ~m1_cyc) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Slave-side request is a pure mux of the granted master; nothing is latched.
   always_comb begin
      s_addr  = gnt1 ? m1_addr : m0_addr;
      s_din   = gnt1 ? m1_din  : m0_din;
      s_we    = gnt1 ? m1_we   : m0_we;
      s_cyc   = (gnt0 & m0_cyc) | (gnt1 & m1_cyc);
      m0_ack  = gnt0 & (s_ack | tmo);
      m1_ack  = gnt1 & (s_ack | tmo);
      m0_err  = gnt0 & tmo;
      m1_err  = gnt1 & tmo;
      m0_dout = (gnt0 & s_ack) ? s_dout : 16'h0000;
      m1_dout = (gnt1 & s_ack) ? s_dout : 16'h0000;
      busy    = (state_q != IDLE);
   end

endmodule

// File: tb/tb_usb_bus_arb.sv
// Randomized bench for usb_bus_arb against a transaction-level ownership model.
module tb_usb_bus_arb;
   localparam int TW   = 3;
   localparam int MAXA = (1 << TW) - 1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] m0_addr, m1_addr, s_addr;
   logic [15:0] m0_din, m1_din, m0_dout, m1_dout, s_din, s_dout;
   logic        m0_cyc, m0_we, m0_lock, m0_ack, m0_err;
   logic        m1_cyc, m1_we, m1_lock, m1_ack, m1_err;
   logic        s_cyc, s_we, s_ack, busy;

   always #5 clk = ~clk;

   usb_bus_arb #(.TIMEOUT_W(TW)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_addr(m0_addr), .m0_din(m0_din), .m0_dout(m0_dout), .m0_cyc(m0_cyc),
      .m0_we(m0_we), .m0_lock(m0_lock), .m0_ack(m0_ack), .m0_err(m0_err),
      .m1_addr(m1_addr), .m1_din(m1_din), .m1_dout(m1_dout), .m1_cyc(m1_cyc),
      .m1_we(m1_we), .m1_lock(m1_lock), .m1_ack(m1_ack), .m1_err(m1_err),
      .s_addr(s_addr), .s_din(s_din), .s_dout(s_dout), .s_cyc(s_cyc),
      .s_we(s_we), .s_ack(s_ack), .busy(busy)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Model: who owns the bus (-1 none), how many cycles it has held it, who won last.
   int owner, last, age;
   bit ackd0, ackd1, pend0, pend1;
   int err_dut, err_mdl;
   int ack_log[$];

   int start0, start1, ack_pct, abort_pct, lock0_pct, lock1_pct;
   bit ack_at_tmo;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      owner = -1; last = 1; age = 0;
      ackd0 = 0; ackd1 = 0; pend0 = 0; pend1 = 0;
   endtask

   task automatic model_check_step();
      logic        cyc_own, tmo, e_cyc, e_ack0, e_ack1, e_err0, e_err1;
      logic [11:0] e_addr;
      logic [15:0] e_din, e_d0, e_d1;
      logic        e_we;
      int          w;
      cyc_own = (owner == 1) ? m1_cyc : m0_cyc;
      tmo     = (owner >= 0) && (age == MAXA) && !s_ack;
      e_cyc   = (owner >= 0) && cyc_own;
      e_addr  = (owner == 1) ? m1_addr : m0_addr;
      e_din   = (owner == 1) ? m1_din  : m0_din;
      e_we    = (owner == 1) ? m1_we   : m0_we;
      e_ack0  = (owner == 0) && (s_ack || tmo);
      e_ack1  = (owner == 1) && (s_ack || tmo);
      e_err0  = (owner == 0) && tmo;
      e_err1  = (owner == 1) && tmo;
      e_d0    = ((owner == 0) && s_ack) ? s_dout : 16'h0;
      e_d1    = ((owner == 1) && s_ack) ? s_dout : 16'h0;

      check_eq("s_bus",   {s_cyc, s_we, s_addr}, {e_cyc, e_we, e_addr});
      check_eq("s_din",   s_din, e_din);
      check_eq("m0_resp", {m0_ack, m0_err, busy}, {e_ack0, e_err0, owner >= 0});
      check_eq("m1_resp", {m1_ack, m1_err, busy}, {e_ack1, e_err1, owner >= 0});
      check_eq("m0_dout", m0_dout, e_d0);
      check_eq("m1_dout", m1_dout, e_d1);

      if (m0_ack) ack_log.push_back(0);
      if (m1_ack) ack_log.push_back(1);
      err_dut += int'(m0_err) + int'(m1_err);
      err_mdl += int'(e_err0) + int'(e_err1);
      ackd0 = e_ack0;
      ackd1 = e_ack1;

      if (!rst_n) begin
         owner = -1; last = 1; age = 0;
      end else if (owner < 0) begin
         w = -1;
         if (m0_cyc && m1_cyc) begin
            if ((last == 1) ? m1_lock : m0_lock) w = last;
            else w = 1 - last;
         end else if (m0_cyc) w = 0;
         else if (m1_cyc) w = 1;
         if (w >= 0) begin
            owner = w; last = w; age = 0;
         end
      end else if (s_ack || tmo || !cyc_own) begin
         owner = -1;
      end else begin
         age++;
      end
   endtask

   task automatic drive();
      if (ackd0) pend0 = 0;
      if (ackd1) pend1 = 0;
      if (pend0 && $urandom_range(99) < abort_pct) pend0 = 0;
      else if (!pend0 && $urandom_range(99) < start0) begin
         pend0 = 1; m0_addr = 12'($urandom); m0_din = 16'($urandom); m0_we = 1'($urandom);
      end
      if (pend1 && $urandom_range(99) < abort_pct) pend1 = 0;
      else if (!pend1 && $urandom_range(99) < start1) begin
         pend1 = 1; m1_addr = 12'($urandom); m1_din = 16'($urandom); m1_we = 1'($urandom);
      end
      m0_cyc  = pend0;
      m1_cyc  = pend1;
      m0_lock = ($urandom_range(99) < lock0_pct);
      m1_lock = ($urandom_range(99) < lock1_pct);
      if (ack_at_tmo) s_ack = (owner >= 0) && (age == MAXA);
      else            s_ack = ($urandom_range(99) < ack_pct);
      s_dout = 16'($urandom);
   endtask

   task automatic run(input int n);
      repeat (n) begin
         drive();
         @(negedge clk);
         model_check_step();
         @(posedge clk);
         #1;
      end
   endtask

   task automatic cfg(input int s0, input int s1, input int ap, input int ab, input int l0, input int l1);
      start0 = s0; start1 = s1; ack_pct = ap; abort_pct = ab; lock0_pct = l0; lock1_pct = l1;
   endtask

   initial begin
      int waited;
      err_dut = 0; err_mdl = 0; ack_at_tmo = 0;
      rst_n = 0;
      m0_addr = 0; m0_din = 0; m0_cyc = 0; m0_we = 0; m0_lock = 0;
      m1_addr = 0; m1_din = 0; m1_cyc = 0; m1_we = 0; m1_lock = 0;
      s_dout = 16'hffff; s_ack = 1;
      model_reset();
      @(negedge clk);
      check_eq("rst_outs", {s_cyc, m0_ack, m1_ack, m0_err, m1_err, busy}, 6'b0);
      check_eq("rst_douts", {m0_dout, m1_dout}, 32'h0);
      @(posedge clk); #1;
      rst_n = 1;

      // Both masters requesting from reset exit, slave acks at once: strict alternation m0 first.
      cfg(100, 100, 100, 0, 0, 0);
      ack_log.delete();
      run(10);
      check_eq("rr_n", ack_log.size() >= 4, 1);
      if (ack_log.size() >= 4)
         check_eq("rr_order", {ack_log[0][1:0], ack_log[1][1:0], ack_log[2][1:0], ack_log[3][1:0]}, 8'b00_01_00_01);

      // m1 locked while both request continuously, slave slow.
      cfg(100, 100, 50, 0, 0, 100);
      run(40);
      cfg(100, 100, 50, 0, 0, 0);
      run(20);

      // Dead slave: m0 times out repeatedly, then m1 is served.
      cfg(100, 0, 0, 0, 0, 0);
      run(25);
      cfg(0, 100, 70, 0, 0, 0);
      run(15);

      // Ack lands exactly on the last watchdog cycle.
      ack_at_tmo = 1;
      cfg(100, 30, 0, 0, 0, 0);
      run(40);
      ack_at_tmo = 0;

      // Async reset while m0 holds the bus.
      cfg(100, 100, 0, 0, 0, 0);
      waited = 0;
      while (!(owner == 0 && age > 0) && waited < 60) begin
         run(1);
         waited++;
      end
      check_eq("rst_wait", waited < 60, 1);
      drive();
      check_eq("pre_rst_cyc", s_cyc, (owner == 0) && m0_cyc);
      #2 rst_n = 0;
      #1;
      check_eq("rst_async", {s_cyc, busy, m0_ack}, 3'b000);
      model_reset();
      @(negedge clk);
      model_check_step();
      @(posedge clk); #1;
      rst_n = 1;
      ack_log.delete();
      cfg(100, 100, 100, 0, 0, 0);
      run(4);
      check_eq("post_rst_first", (ack_log.size() > 0) ? ack_log[0] : 9, 0);

      // Random mix including aborts, locks and stray acks.
      cfg(30, 30, 40, 3, 20, 20);
      run(1500);
      cfg(60, 60, 5, 2, 50, 50);
      run(600);

      check_eq("err_count", err_dut, err_mdl);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1);
   end
endmodule
